// File: rtl/jam_scheduler_pkg.sv
// Shared traffic package: scheduler state encoding, default timing
// constants and a small lane-decode helper used by the jam scheduler
// and the control unit.
package jam_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CLEAR = 2'd2
    } jam_state_e;

    localparam int DEF_GREEN_MIN = 4;
    localparam int DEF_GREEN_MAX = 16;
    localparam int DEF_CLEAR_CYC = 2;

    // Width of the green and clearance counters; timing constants must fit.
    localparam int CNT_W = 5;

    // Converts a lane index into a single green bit.
    function automatic logic [3:0] lane_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/jam_scheduler_if.sv
// Bundle between the control unit and the jam scheduler: jam-mode enable
// and lane jam flags in, registered green pattern and status out.
interface jam_scheduler_if;

    logic       en;
    logic [3:0] traffic_jam;
    logic [3:0] allow_jam;
    logic [1:0] grant_id;
    logic       busy;

    modport master (
        output en,
        output traffic_jam,
        input  allow_jam,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  en,
        input  traffic_jam,
        output allow_jam,
        output grant_id,
        output busy
    );

endinterface

// File: rtl/rr_pick4.sv
// Four-lane round-robin picker: returns the first requesting lane after
// ptr (wrapping), with ptr itself checked last so a lone requester can
// win again.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] sel,
    output logic       any
);

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        sel = ptr;
        any = |req;
        for (int k = 3; k >= 1; k--) begin
            if (req[ptr + 2'(k)]) begin
                sel = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/jam_scheduler.sv
// Jam-mode green scheduler: grants one jammed lane at a time in round-robin
// order, holds green between GREEN_MIN and GREEN_MAX cycles, and inserts
// CLEAR_CYC all-red cycles between grants. Every output is a flop.
module jam_scheduler
    import jam_scheduler_pkg::*;
#(
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int CLEAR_CYC = DEF_CLEAR_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    jam_scheduler_if.slave  bus
);

    localparam logic [CNT_W-1:0] GMIN_C = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GMAX_C = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] CLR_C  = CNT_W'(CLEAR_CYC);

    jam_state_e       state_q, state_d;
    logic [3:0]       allow_q, allow_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0] clear_cnt_q, clear_cnt_d;
    logic             busy_q, busy_d;
    logic             grant_now;
    logic [1:0]       pick_sel;
    logic             pick_any;

    rr_pick4 u_pick (
        .req (bus.traffic_jam),
        .ptr (rr_ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    // Next-state logic: enable drop wins, then per-state sequencing, then a
    // common grant-issue path shared by IDLE and the end of CLEAR.
    always_comb begin
        state_d     = state_q;
        allow_d     = allow_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        green_cnt_d = green_cnt_q;
        clear_cnt_d = clear_cnt_q;
        grant_now   = 1'b0;

        if (!bus.en) begin
            state_d     = IDLE;
            allow_d     = 4'b0000;
            green_cnt_d = '0;
            clear_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_now = 1'b1;
                    end
                end
                GRANT: begin
                    if ((green_cnt_q >= GMIN_C && !bus.traffic_jam[grant_q]) ||
                        green_cnt_q == GMAX_C) begin
                        state_d     = CLEAR;
                        allow_d     = 4'b0000;
                        green_cnt_d = '0;
                        clear_cnt_d = CNT_W'(1);
                    end else if (green_cnt_q < GMAX_C) begin
                        green_cnt_d = green_cnt_q + CNT_W'(1);
                    end
                end
                CLEAR: begin
                    if (clear_cnt_q >= CLR_C) begin
                        clear_cnt_d = '0;
                        if (pick_any) begin
                            grant_now = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        clear_cnt_d = clear_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    allow_d = 4'b0000;
                end
            endcase
        end

        if (grant_now) begin
            state_d     = GRANT;
            allow_d     = lane_onehot(pick_sel);
            grant_d     = pick_sel;
            rr_ptr_d    = pick_sel;
            green_cnt_d = CNT_W'(1);
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset points the pointer at lane 3 so lane 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            allow_q     <= 4'b0000;
            grant_q     <= 2'd3;
            rr_ptr_q    <= 2'd3;
            green_cnt_q <= '0;
            clear_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            allow_q     <= allow_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            green_cnt_q <= green_cnt_d;
            clear_cnt_q <= clear_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.allow_jam = allow_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_jam_scheduler.sv
// Scoreboard bench for jam_scheduler: a lane-level reference model pushes
// the expected outputs for every clock edge, and an independent monitor
// pops and compares them, along with one-hot and clearance-gap checks.
module tb_jam_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 16;
    localparam int CLR  = 2;

    typedef struct {
        logic [3:0] allow;
        logic [1:0] gid;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    jam_scheduler_if bus ();

    jam_scheduler #(
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .CLEAR_CYC (CLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: current green lane (-1 none), cycles spent green,
    // position inside the all-red gap (0 when not clearing), last granted lane.
    int m_lane  = -1;
    int m_green = 0;
    int m_clear = 0;
    int m_last  = 3;

    // Monitor-side run trackers for the clearance-gap property.
    int         zero_run   = 0;
    int         green_run  = 0;
    bit         seen_green = 1'b0;
    logic [3:0] prev_allow = 4'b0000;

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_lane(input logic [3:0] jam, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (jam[c]) return c;
        end
        return -1;
    endfunction

    // Advances the model by one rising edge with the sampled inputs and
    // queues what the DUT should show after that edge.
    task automatic model_step(input logic en_v, input logic [3:0] jam_v);
        exp_t e;
        int   l;
        if (!en_v) begin
            m_lane  = -1;
            m_clear = 0;
        end else if (m_lane >= 0) begin
            if ((m_green >= GMIN && !jam_v[m_lane]) || m_green >= GMAX) begin
                m_lane  = -1;
                m_clear = 1;
            end else begin
                m_green++;
            end
        end else if (m_clear > 0 && m_clear < CLR) begin
            m_clear++;
        end else begin
            m_clear = 0;
            l = pick_lane(jam_v, m_last);
            if (l >= 0) begin
                m_lane  = l;
                m_last  = l;
                m_green = 1;
            end
        end
        e.allow = (m_lane >= 0) ? 4'(1 << m_lane) : 4'b0000;
        e.gid   = 2'(m_last);
        e.busy  = (m_lane >= 0) || (m_clear > 0);
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic en_v, input logic [3:0] jam_v);
        @(negedge clk);
        bus.en          = en_v;
        bus.traffic_jam = jam_v;
        @(posedge clk);
        model_step(en_v, jam_v);
    endtask

    // Asserts reset between clock edges and checks that the outputs clear
    // without waiting for a clock.
    task automatic apply_reset();
        @(negedge clk);
        bus.en          = 1'b0;
        bus.traffic_jam = 4'b0000;
        rst_n           = 1'b0;
        #1;
        check_val("rst_allow_jam", int'(bus.allow_jam), 0);
        check_val("rst_grant_id", int'(bus.grant_id), 3);
        check_val("rst_busy", int'(bus.busy), 0);
        exp_q.delete();
        m_lane     = -1;
        m_green    = 0;
        m_clear    = 0;
        m_last     = 3;
        zero_run   = 0;
        green_run  = 0;
        seen_green = 1'b0;
        prev_allow = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_output(input exp_t e);
        check_val("allow_jam", int'(bus.allow_jam), int'(e.allow));
        check_val("grant_id", int'(bus.grant_id), int'(e.gid));
        check_val("busy", int'(bus.busy), int'(e.busy));
        check_val("onehot_or_zero", int'($countones(bus.allow_jam) <= 1), 1);
        if (!bus.en) begin
            seen_green = 1'b0;
        end
        if (bus.allow_jam == 4'b0000) begin
            zero_run++;
            green_run = 0;
        end else begin
            if (green_run == 0 && seen_green) begin
                check_val("clear_gap_ok", int'(zero_run >= CLR), 1);
            end
            if (green_run > 0) begin
                check_val("lane_hold", int'(bus.allow_jam), int'(prev_allow));
            end
            green_run++;
            check_val("green_len_ok", int'(green_run <= GMAX), 1);
            zero_run   = 0;
            seen_green = 1'b1;
        end
        prev_allow = bus.allow_jam;
    endtask

    // Monitor: one step after each rising edge, compare against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check_output(exp_q.pop_front());
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized jam traffic.
    initial begin
        int         hold;
        logic [3:0] jam_r;
        logic       en_r;

        rst_n           = 1'b0;
        bus.en          = 1'b0;
        bus.traffic_jam = 4'b0000;
        apply_reset();

        // Single jammed lane 0: 16 green, 2 red, then lane 0 again.
        repeat (40) apply_stimulus(1'b1, 4'b0001);

        // Lanes 1 and 2 alternate at maximum green.
        apply_reset();
        repeat (40) apply_stimulus(1'b1, 4'b0110);

        // Lane 3 jam pulse of one cycle: minimum green then back to idle.
        apply_stimulus(1'b0, 4'b0000);
        apply_stimulus(1'b1, 4'b1000);
        repeat (10) apply_stimulus(1'b1, 4'b0000);

        // Enable drop at green cycle 3, then all lanes jammed.
        apply_stimulus(1'b1, 4'b0100);
        apply_stimulus(1'b1, 4'b0100);
        apply_stimulus(1'b1, 4'b0100);
        apply_stimulus(1'b0, 4'b0100);
        repeat (6) apply_stimulus(1'b1, 4'b1111);

        // Reset pulsed in the middle of a grant.
        apply_stimulus(1'b1, 4'b0010);
        apply_stimulus(1'b1, 4'b0010);
        apply_reset();
        repeat (5) apply_stimulus(1'b1, 4'b0010);

        // Randomized traffic with held jam patterns and sparse enable drops.
        hold  = 0;
        jam_r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                jam_r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                hold  = $urandom_range(1, 20);
            end
            hold--;
            en_r = ($urandom_range(0, 24) != 0);
            if (i == 300) begin
                apply_reset();
            end
            apply_stimulus(en_r, jam_r);
        end

        repeat (3) @(negedge clk);
        check_val("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
